serial_addsub: RTL and testbench

Parametrised digit-serial adder/subtractor, the multi-cycle successor of the team's fixed-width ripple-carry adders. It accepts WIDTH-bit operands through a valid/ready handshake and processes DIGIT bits per clock, LSB first, through one DIGIT-wide ripple slice. It returns sum, carry/borrow and signed overflow through a second valid/ready handshake. Used where wide add/sub is needed at low area and a few cycles of latency are acceptable.

---
 rtl/addsub_pkg.sv | 23 ++
 rtl/digit_adder.sv | 31 +++
 rtl/fulladder.sv | 13 +
 rtl/serial_addsub.sv | 145 ++++++++++++++
 tb/tb_serial_addsub.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/addsub_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder/subtractor.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned calc_ndig(input int unsigned width, input int unsigned digit);
    return width / digit;
  endfunction

  // Digit counter width: clog2 of the digit count, never narrower than one bit.
  function automatic int unsigned calc_cnt_w(input int unsigned ndig);
    return (ndig <= 1) ? 1 : $clog2(ndig);
  endfunction

  function automatic bit params_ok(input int unsigned width, input int unsigned digit);
    return (width >= 2) && (digit >= 1) && (digit <= width) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/digit_adder.sv
// DIGIT-wide ripple-carry slice built from full adders; purely combinational.
module digit_adder #(
  parameter int unsigned DIGIT = 4
) (
  input  logic [DIGIT-1:0] A,
  input  logic [DIGIT-1:0] B,
  input  logic             Cin,
  output logic [DIGIT-1:0] Sum,
  output logic             Cout,
  output logic             Cmsb
);

  logic [DIGIT:0] w_c;

  assign w_c[0] = Cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    fulladder u_fa (
      .i_a      (A[i]),
      .i_b      (B[i]),
      .i_c      (w_c[i]),
      .o_sum_c  (Sum[i]),
      .o_cout_c (w_c[i+1])
    );
  end

  assign Cout = w_c[DIGIT];
  // Carry into the top bit of this slice; on the last digit it feeds signed overflow.
  assign Cmsb = w_c[DIGIT-1];

endmodule

// File: rtl/fulladder.sv
// Single-bit full adder cell.
module fulladder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_sum_c,
  output logic o_cout_c
);

  assign o_sum_c  = i_a ^ i_b ^ i_c;
  assign o_cout_c = (i_a & i_b) | (i_c & (i_a ^ i_b));

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial WIDTH-bit adder/subtractor, DIGIT bits per cycle LSB first,
// with valid/ready handshakes on both the operand and result sides.
module serial_addsub
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Sub,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int unsigned NDIG  = calc_ndig(WIDTH, DIGIT);
  localparam int unsigned CNT_W = calc_cnt_w(NDIG);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NDIG - 1);

  if (!params_ok(WIDTH, DIGIT)) begin : g_param_check
    $error("serial_addsub: WIDTH must be >= 2 and an integer multiple of DIGIT");
  end

  state_t             r_state;
  state_t             w_next;
  logic               w_accept;
  logic               w_step;
  logic               w_last;

  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_sum;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_cout;
  logic               r_ovf;
  logic               r_in_ready;
  logic               r_out_valid;

  logic [DIGIT-1:0]   w_dsum;
  logic               w_dcout;
  logic               w_dcmsb;

  digit_adder #(
    .DIGIT (DIGIT)
  ) u_digit (
    .A    (r_a[DIGIT-1:0]),
    .B    (r_b[DIGIT-1:0]),
    .Cin  (r_carry),
    .Sum  (w_dsum),
    .Cout (w_dcout),
    .Cmsb (w_dcmsb)
  );

  // Next-state and datapath control.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_step   = 1'b0;
    w_last   = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_accept = 1'b1;
          w_next   = RUN;
        end
      end
      RUN: begin
        w_step = 1'b1;
        if (r_cnt == LAST_CNT) begin
          w_last = 1'b1;
          w_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Handshake flags are registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_in_ready  <= (w_next == IDLE);
      r_out_valid <= (w_next == DONE);
    end
  end

  // Subtraction is A + ~B + ~Cin: B is inverted at load, Cin folded into the carry seed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= A;
      r_b     <= Sub ? ~B : B;
      r_carry <= Cin ^ Sub;
      r_cnt   <= '0;
    end else if (w_step) begin
      r_a     <= r_a >> DIGIT;
      r_b     <= r_b >> DIGIT;
      r_sum   <= WIDTH'({w_dsum, r_sum} >> DIGIT);
      r_carry <= w_dcout;
      r_cnt   <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_cout <= w_dcout;
        r_ovf  <= w_dcmsb ^ w_dcout;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign Sum       = r_sum;
  assign Cout      = r_cout;
  assign Ovf       = r_ovf;

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: directed cases, backpressure, reset abort and a
// randomized sweep over several WIDTH/DIGIT configurations against an arithmetic model.
module tb_serial_addsub;

  localparam int NCFG = 6;
  localparam int unsigned CW [NCFG] = '{16, 16, 16, 16, 16, 8};
  localparam int unsigned CD [NCFG] = '{4, 1, 2, 8, 16, 8};

  logic        clk;
  logic        rst;
  logic        iv   [NCFG];
  logic        ir   [NCFG];
  logic [15:0] a    [NCFG];
  logic [15:0] b    [NCFG];
  logic        sub  [NCFG];
  logic        cin  [NCFG];
  logic        ov   [NCFG];
  logic        ordy [NCFG];
  logic [15:0] sum  [NCFG];
  logic        cout [NCFG];
  logic        ovf  [NCFG];

  int n_checks = 0;
  int n_errors = 0;

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    localparam int unsigned W = CW[g];
    localparam int unsigned D = CD[g];
    logic [W-1:0] w_sum;
    serial_addsub #(.WIDTH(W), .DIGIT(D)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (iv[g]),
      .in_ready  (ir[g]),
      .A         (a[g][W-1:0]),
      .B         (b[g][W-1:0]),
      .Sub       (sub[g]),
      .Cin       (cin[g]),
      .out_valid (ov[g]),
      .out_ready (ordy[g]),
      .Sum       (w_sum),
      .Cout      (cout[g]),
      .Ovf       (ovf[g])
    );
    assign sum[g] = 16'(w_sum);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  task automatic ref_model(input int unsigned w, input longint av, input longint bv,
                           input bit sv, input bit cv,
                           output logic [15:0] s, output bit co, output bit ofl);
    longint half, full, sa, sb, r, sr;
    half = longint'(1) << (w - 1);
    full = half * 2;
    sa = (av >= half) ? av - full : av;
    sb = (bv >= half) ? bv - full : bv;
    if (sv) begin
      r  = av - bv - longint'(cv);
      sr = sa - sb - longint'(cv);
      co = (r >= 0);
    end else begin
      r  = av + bv + longint'(cv);
      sr = sa + sb + longint'(cv);
      co = (r >= full);
    end
    s   = 16'((r % full + full) % full);
    ofl = (sr < -half) || (sr > half - 1);
  endtask

  task automatic start_op(input int k, input logic [15:0] av, input logic [15:0] bv,
                          input logic sv, input logic cv, output bit ok);
    int n = 0;
    while (!ir[k] && n < 50) begin
      @(posedge clk); #1; n++;
    end
    ok = ir[k];
    if (!ok) begin
      chk("in_ready_timeout", 0, 1);
      return;
    end
    a[k] = av; b[k] = bv; sub[k] = sv; cin[k] = cv; iv[k] = 1'b1;
    @(posedge clk); #1;
    iv[k] = 1'b0;
    // Operands are don't-care after the accept edge.
    a[k] = 16'($urandom); b[k] = 16'($urandom);
    sub[k] = 1'($urandom); cin[k] = 1'($urandom);
  endtask

  task automatic wait_valid(input int k, output bit ok);
    int lat = 0;
    while (!ov[k] && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    chk($sformatf("latency_cfg%0d", k), lat, CW[k] / CD[k]);
    ok = ov[k];
  endtask

  task automatic finish_op(input int k, input logic [15:0] es, input bit ec, input bit eo,
                           input bit rnd);
    int n = 0;
    bit done = 0;
    bit r;
    while (!done && n < 200) begin
      r = rnd ? 1'($urandom) : 1'b1;
      ordy[k] = r;
      iv[k]   = rnd ? 1'($urandom) : 1'b0;
      if (r) begin
        chk($sformatf("sum_cfg%0d", k), sum[k], es);
        chk($sformatf("cout_cfg%0d", k), cout[k], ec);
        chk($sformatf("ovf_cfg%0d", k), ovf[k], eo);
      end
      @(posedge clk); #1; n++;
      if (r) done = 1;
    end
    ordy[k] = 1'b0;
    iv[k]   = 1'b0;
    if (!done) chk("handshake_timeout", 0, 1);
    chk($sformatf("valid_drop_cfg%0d", k), ov[k], 0);
    chk($sformatf("ready_back_cfg%0d", k), ir[k], 1);
    chk($sformatf("sum_hold_cfg%0d", k), sum[k], es);
  endtask

  task automatic run_op(input int k, input logic [15:0] av, input logic [15:0] bv,
                        input logic sv, input logic cv,
                        input logic [15:0] es, input bit ec, input bit eo, input bit rnd);
    bit ok;
    start_op(k, av, bv, sv, cv, ok);
    if (!ok) return;
    chk($sformatf("busy_cfg%0d", k), ir[k], 0);
    wait_valid(k, ok);
    if (!ok) return;
    finish_op(k, es, ec, eo, rnd);
  endtask

  task automatic run_rand(input int k, input int nops);
    logic [15:0] av, bv, es;
    logic sv, cv;
    bit ec, eo;
    longint mask;
    mask = (longint'(1) << CW[k]) - 1;
    for (int i = 0; i < nops; i++) begin
      av = 16'(longint'($urandom) & mask);
      bv = 16'(longint'($urandom) & mask);
      sv = 1'($urandom);
      cv = 1'($urandom);
      ref_model(CW[k], longint'(av), longint'(bv), sv, cv, es, ec, eo);
      run_op(k, av, bv, sv, cv, es, ec, eo, 1'b1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    bit seen;
    rst = 1'b1;
    for (int k = 0; k < NCFG; k++) begin
      iv[k] = 0; ordy[k] = 0; a[k] = 0; b[k] = 0; sub[k] = 0; cin[k] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_in_ready", ir[0], 1);
    chk("rst_out_valid", ov[0], 0);
    chk("rst_sum", sum[0], 0);
    chk("rst_cout", cout[0], 0);
    chk("rst_ovf", ovf[0], 0);

    // Directed arithmetic, results from the expected table.
    run_op(0, 16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0);
    run_op(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    run_op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0);
    run_op(0, 16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    run_op(0, 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    run_op(0, 16'h0010, 16'h0000, 1'b1, 1'b1, 16'h000F, 1'b1, 1'b0, 1'b0);

    // Backpressure: result held for five cycles while in_valid pulses are ignored.
    start_op(0, 16'h00FF, 16'h0001, 1'b0, 1'b0, ok);
    if (ok) wait_valid(0, ok);
    if (ok) begin
      ordy[0] = 1'b0;
      for (int i = 0; i < 5; i++) begin
        iv[0] = 1'b1; a[0] = 16'($urandom); b[0] = 16'($urandom);
        @(posedge clk); #1;
        chk("bp_valid", ov[0], 1);
        chk("bp_in_ready", ir[0], 0);
        chk("bp_sum", sum[0], 16'h0100);
        chk("bp_cout", cout[0], 0);
        chk("bp_ovf", ovf[0], 0);
      end
      iv[0] = 1'b0;
      finish_op(0, 16'h0100, 1'b0, 1'b0, 1'b0);
    end

    // Make Ovf=1 so that reset clearing it is observable.
    run_op(0, 16'h7FFF, 16'h7FFF, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b0);

    // Reset during the second RUN cycle abandons the operation.
    start_op(0, 16'h1234, 16'h0FFF, 1'b0, 1'b0, ok);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_in_ready", ir[0], 1);
    chk("abort_out_valid", ov[0], 0);
    chk("abort_sum", sum[0], 0);
    chk("abort_cout", cout[0], 0);
    chk("abort_ovf", ovf[0], 0);
    seen = 0;
    ordy[0] = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (ov[0]) seen = 1;
    end
    ordy[0] = 1'b0;
    chk("abort_no_result", seen, 0);
    run_op(0, 16'hABCD, 16'h1111, 1'b1, 1'b0, 16'h9ABC, 1'b1, 1'b0, 1'b0);

    // Randomized sweep on every configuration in parallel.
    fork
      run_rand(0, 300);
      run_rand(1, 1000);
      run_rand(2, 1000);
      run_rand(3, 1000);
      run_rand(4, 1000);
      run_rand(5, 1000);
    join

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
